fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline. It sits directly upstream of decode and owns the PC. It issues word reads to the instruction cache and hands each returned instruction, with its PC+4, to the IF/ID latch using a one-cycle enable. It absorbs decode stalls with a one-entry hold buffer, services branch/jump redirects with a flush, and stops fetching on halt.

---
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_stage.sv | 125 ++++++++++++
 tb/tb_fetch_stage.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: icache request/response, hazard and redirect controls
// coming in, and the IF/ID latch feed going out.
interface fetch_stage_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        ihit;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] instru;
    logic [31:0] nPC;
    logic        deen;
    logic        flush;

    // master: the fetch stage itself
    modport master (
        output iREN, iaddr, instru, nPC, deen, flush,
        input  iload, ihit, stall, redirect, redirect_pc, halt
    );

    // slave: icache, hazard unit and IF/ID latch seen as one environment
    modport slave (
        input  iREN, iaddr, instru, nPC, deen, flush,
        output iload, ihit, stall, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads the icache, absorbs decode
// stalls in a one-entry hold buffer, handles redirects and halt.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          WORD_W  = 32
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WORD_W-1:0]  pc_reg, pc_next;
    logic [WORD_W-1:0]  hold_instr_reg, hold_instr_next;
    logic [WORD_W-1:0]  hold_pc_reg, hold_pc_next;
    logic [WORD_W-1:0]  pc_plus4;
    logic [WORD_W-1:0]  hold_pc_plus4;

    logic               iren;
    logic [WORD_W-1:0]  instru;
    logic [WORD_W-1:0]  npc;
    logic               deen;
    logic               flush;

    assign pc_plus4      = pc_reg + WORD_W'(4);
    assign hold_pc_plus4 = hold_pc_reg + WORD_W'(4);

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        hold_instr_next = hold_instr_reg;
        hold_pc_next    = hold_pc_reg;
        iren            = 1'b0;
        instru          = '0;
        npc             = '0;
        deen            = 1'b0;
        flush           = 1'b0;

        case (state_reg)
            RUN: begin
                iren   = 1'b1;
                instru = bus.iload;
                npc    = pc_plus4;
            end
            HOLD: begin
                instru = hold_instr_reg;
                npc    = hold_pc_plus4;
            end
            default: ;
        endcase

        if (bus.redirect) begin
            // Redirect wins over everything; a same-cycle hit is stale.
            flush           = 1'b1;
            pc_next         = {bus.redirect_pc[WORD_W-1:2], 2'b00};
            hold_instr_next = '0;
            hold_pc_next    = '0;
            state_next      = RUN;
        end else if (bus.halt && (state_reg != HALTED)) begin
            // Anything held is younger than the halt, so it is dropped.
            hold_instr_next = '0;
            hold_pc_next    = '0;
            state_next      = HALTED;
        end else begin
            case (state_reg)
                RUN: begin
                    if (bus.ihit) begin
                        pc_next = pc_plus4;
                        if (bus.stall) begin
                            hold_instr_next = bus.iload;
                            hold_pc_next    = pc_reg;
                            state_next      = HOLD;
                        end else begin
                            deen = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!bus.stall) begin
                        deen       = 1'b1;
                        state_next = RUN;
                    end
                end
                default: ;
            endcase
        end

        // Outputs are forced quiet for as long as reset is held.
        if (RST) begin
            iren   = 1'b0;
            instru = '0;
            npc    = '0;
            deen   = 1'b0;
            flush  = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg      <= RUN;
            pc_reg         <= PC_INIT;
            hold_instr_reg <= '0;
            hold_pc_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            hold_instr_reg <= hold_instr_next;
            hold_pc_reg    <= hold_pc_next;
        end
    end

    assign bus.iREN   = iren;
    assign bus.iaddr  = pc_reg;
    assign bus.instru = instru;
    assign bus.nPC    = npc;
    assign bus.deen   = deen;
    assign bus.flush  = flush;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver queues expected IF/ID
// deliveries and flushes, a negedge monitor pops and compares them.
module tb_fetch_stage;

    logic CLK;
    logic RST;

    fetch_stage_if bus ();

    fetch_stage #(.PC_INIT(32'h0000_0000), .WORD_W(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit          is_flush;
        logic [31:0] instr;
        logic [31:0] npc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Instruction memory image: one distinctive word, the rest address-tagged.
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0000_0020) return 32'h8C22_0004;
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    always_comb bus.iload = mem(bus.iaddr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_del(input logic [31:0] instr, input logic [31:0] npc);
        exp_t e;
        e.is_flush = 1'b0;
        e.instr    = instr;
        e.npc      = npc;
        q.push_back(e);
    endtask

    task automatic push_flush();
        exp_t e;
        e.is_flush = 1'b1;
        e.instr    = '0;
        e.npc      = '0;
        q.push_back(e);
    endtask

    // One cycle: drive inputs, check request side at negedge, return after edge.
    task automatic step(input bit hit, input bit st, input bit rd, input logic [31:0] rpc,
                        input bit hl, input bit exp_iren, input logic [31:0] exp_addr);
        bus.ihit        = hit;
        bus.stall       = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.halt        = hl;
        @(negedge CLK);
        chk("iREN", {31'b0, bus.iREN}, {31'b0, exp_iren});
        chk("iaddr", bus.iaddr, exp_addr);
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every deen/flush pulse must match the head of the queue.
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (RST) begin
            chk("reset_quiet", {30'b0, bus.deen, bus.flush}, 32'h0);
        end else begin
            if (bus.deen && bus.flush)
                chk("deen_flush_exclusive", 32'h1, 32'h0);
            if (bus.deen || bus.flush) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {30'b0, bus.deen, bus.flush}, 32'h0);
                end else begin
                    e = q.pop_front();
                    chk("pulse_kind", {31'b0, bus.flush}, {31'b0, e.is_flush});
                    if (!e.is_flush) begin
                        chk("instru", bus.instru, e.instr);
                        chk("nPC", bus.nPC, e.npc);
                    end
                end
            end
        end
    end

    initial begin
        RST             = 1'b1;
        bus.ihit        = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halt        = 1'b0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_iREN", {31'b0, bus.iREN}, 32'h0);
        chk("rst_instru", bus.instru, 32'h0);
        chk("rst_nPC", bus.nPC, 32'h0);
        chk("rst_iaddr", bus.iaddr, 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Straight-line fetch 0..C
        for (int a = 0; a < 16; a += 4) begin
            push_del(mem(32'(a)), 32'(a + 4));
            step(1, 0, 0, 0, 0, 1, 32'(a));
        end

        // Three misses at 0x10, then hit
        repeat (3) step(0, 0, 0, 0, 0, 1, 32'h10);
        push_del(mem(32'h10), 32'h14);
        step(1, 0, 0, 0, 0, 1, 32'h10);
        for (int a = 32'h14; a < 32'h20; a += 4) begin
            push_del(mem(32'(a)), 32'(a + 4));
            step(1, 0, 0, 0, 0, 1, 32'(a));
        end

        // Hit at 0x20 under stall, held one more cycle, then delivered
        step(1, 1, 0, 0, 0, 1, 32'h20);
        bus.ihit  = 1'b0;
        bus.stall = 1'b1;
        @(negedge CLK);
        chk("hold_iREN", {31'b0, bus.iREN}, 32'h0);
        chk("hold_instru", bus.instru, 32'h8C22_0004);
        chk("hold_nPC", bus.nPC, 32'h24);
        @(posedge CLK);
        #1;
        push_del(32'h8C22_0004, 32'h24);
        step(0, 0, 0, 0, 0, 0, 32'h24);
        push_del(mem(32'h24), 32'h28);
        step(1, 0, 0, 0, 0, 1, 32'h24);

        // Redirect while holding 0x28: held word must never appear
        step(1, 1, 0, 0, 0, 1, 32'h28);
        push_flush();
        step(0, 1, 1, 32'h103, 0, 0, 32'h2C);
        push_del(mem(32'h100), 32'h104);
        step(1, 0, 0, 0, 0, 1, 32'h100);

        // Redirect to 0x40 (ihit ignored), halt there, sit 10 cycles, redirect out
        push_flush();
        step(1, 0, 1, 32'h40, 0, 1, 32'h104);
        step(1, 0, 0, 0, 1, 1, 32'h40);
        repeat (10) step(1, 0, 0, 0, 0, 0, 32'h40);
        push_flush();
        step(0, 0, 1, 32'h80, 0, 0, 32'h40);
        push_del(mem(32'h80), 32'h84);
        step(1, 0, 0, 0, 0, 1, 32'h80);

        // Reset in HOLD with redirect high
        step(1, 1, 0, 0, 0, 1, 32'h84);
        RST          = 1'b1;
        bus.redirect = 1'b1;
        bus.stall    = 1'b1;
        @(negedge CLK);
        chk("midrst_iREN", {31'b0, bus.iREN}, 32'h0);
        chk("midrst_instru", bus.instru, 32'h0);
        chk("midrst_nPC", bus.nPC, 32'h0);
        chk("midrst_iaddr", bus.iaddr, 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        push_del(mem(32'h0), 32'h4);
        step(1, 0, 0, 0, 0, 1, 32'h0);
        push_del(mem(32'h4), 32'h8);
        step(1, 0, 0, 0, 0, 1, 32'h4);

        step(0, 0, 0, 0, 0, 1, 32'h8);
        chk("queue_drained", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
